// File: rtl/idelay3_drp_if.sv
`default_nettype none
// ============================================================================
//  Module   : idelay3_drp_if
//  Purpose  : Register-port bundle between the multi-channel delay core and
//             one idelay3_drp channel (tap load / read-back handshake).
//  Signals  : read      - one-cycle request to capture the current tap value
//             change    - one-cycle request to load delay_in as the new tap
//             EN_VTC    - static preference: keep VTC on while idle
//             delay_in  - new tap value, sampled only when change is accepted
//             done      - one-cycle completion pulse (read or change)
//             delay_out - last captured tap value
//  Modports : master (core side), slave (channel side)
//  Revision : 1.0 - initial release
// ============================================================================
interface idelay3_drp_if;
    logic       read;
    logic       change;
    logic       EN_VTC;
    logic [8:0] delay_in;
    logic       done;
    logic [8:0] delay_out;

    modport master (
        output read,
        output change,
        output EN_VTC,
        output delay_in,
        input  done,
        input  delay_out
    );

    modport slave (
        input  read,
        input  change,
        input  EN_VTC,
        input  delay_in,
        output done,
        output delay_out
    );
endinterface
`default_nettype wire

// File: rtl/idelay3_drp.sv
`default_nettype none
// ============================================================================
//  Module   : idelay3_drp
//  Purpose  : One programmable input delay line (IDELAYE3, VAR_LOAD) with a
//             control FSM that loads a new 9-bit tap value under the VTC
//             handshake and reads back the current tap value.
//  Ports    : clk      - control clock, also the delay element clock
//             rst_n    - synchronous active-low reset
//             data_in  - signal to delay
//             data_out - delayed signal (combinational through the element)
//             bus      - idelay3_drp_if.slave register handshake
//  Params   : REFCLK_FREQUENCY - IDELAYCTRL reference clock in MHz
//             MODE             - delay format, "TIME" or "COUNT"
//  Revision : 1.0 - initial release
// ============================================================================
module idelay3_drp #(
    parameter real   REFCLK_FREQUENCY = 300.0,
    parameter string MODE             = "TIME"
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          data_in,
    output wire logic          data_out,
    idelay3_drp_if.slave       bus
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_VTC_OFF_WAIT = 3'd1;
    localparam logic [2:0] S_LOAD         = 3'd2;
    localparam logic [2:0] S_LOAD_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE      = 3'd4;
    localparam logic [2:0] S_VTC_ON_WAIT  = 3'd5;
    localparam logic [2:0] S_RD_CAPTURE   = 3'd6;

    // The element needs 10 clocks after VTC is dropped before a load, and
    // the same settling time is given after VTC is handed back.
    localparam logic [3:0] VTC_WAIT_LAST = 4'd9;
    // CNTVALUEOUT needs two clocks after LOAD before it is trustworthy.
    localparam logic [3:0] SETTLE_LAST   = 4'd1;

    // Configurations outside the element's legal range get no delay line.
    localparam bit CFG_OK = ((MODE == "TIME") || (MODE == "COUNT")) &&
                            (REFCLK_FREQUENCY >= 200.0) &&
                            (REFCLK_FREQUENCY <= 2667.0);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic       r_done;
    logic [8:0] r_delay_out;
    logic       r_load;
    logic       r_en_vtc;
    logic [8:0] r_latched;
    logic       r_prim_rst;
    logic [8:0] w_cntvalueout;

    assign bus.done      = r_done;
    assign bus.delay_out = r_delay_out;

    // Element reset is a registered copy of the FSM reset so both leave
    // reset on the same clock boundary.
    always_ff @(posedge clk) begin
        r_prim_rst <= !rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_done      <= 1'b0;
            r_delay_out <= 9'd0;
            r_load      <= 1'b0;
            r_en_vtc    <= bus.EN_VTC;
            r_latched   <= 9'd0;
        end else begin
            r_done <= 1'b0;
            r_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // change has priority; a simultaneous read is dropped
                    if (bus.change) begin
                        r_latched <= bus.delay_in;
                        r_en_vtc  <= 1'b0;
                        r_cnt     <= 4'd0;
                        r_state   <= S_VTC_OFF_WAIT;
                    end else begin
                        r_en_vtc <= bus.EN_VTC;
                        if (bus.read) begin
                            r_state <= S_RD_CAPTURE;
                        end
                    end
                end
                S_VTC_OFF_WAIT: begin
                    r_en_vtc <= 1'b0;
                    if (r_cnt == VTC_WAIT_LAST) begin
                        r_cnt   <= 4'd0;
                        // strobe is raised on entry so LOAD is high for
                        // exactly the one cycle spent in S_LOAD
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_LOAD_WAIT;
                end
                S_LOAD_WAIT: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_delay_out <= w_cntvalueout;
                    r_en_vtc    <= bus.EN_VTC;
                    r_cnt       <= 4'd0;
                    r_state     <= S_VTC_ON_WAIT;
                end
                S_VTC_ON_WAIT: begin
                    if (r_cnt == VTC_WAIT_LAST) begin
                        r_cnt   <= 4'd0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RD_CAPTURE: begin
                    r_delay_out <= w_cntvalueout;
                    r_done      <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    generate
        if (CFG_OK) begin : g_delay
`ifdef IDELAY3_DRP_UNISIM
            IDELAYE3 #(
                .CASCADE          ("NONE"),
                .DELAY_FORMAT     (MODE),
                .DELAY_SRC        ("IDATAIN"),
                .DELAY_TYPE       ("VAR_LOAD"),
                .DELAY_VALUE      (0),
                .IS_CLK_INVERTED  (1'b0),
                .IS_RST_INVERTED  (1'b0),
                .REFCLK_FREQUENCY (REFCLK_FREQUENCY),
                .SIM_DEVICE       ("ULTRASCALE"),
                .UPDATE_MODE      ("ASYNC")
            ) u_idelaye3 (
                .CASC_OUT    (),
                .CNTVALUEOUT (w_cntvalueout),
                .DATAOUT     (data_out),
                .CASC_IN     (1'b0),
                .CASC_RETURN (1'b0),
                .CE          (1'b0),
                .CLK         (clk),
                .CNTVALUEIN  (r_latched),
                .DATAIN      (1'b0),
                .EN_VTC      (r_en_vtc),
                .IDATAIN     (data_in),
                .INC         (1'b0),
                .LOAD        (r_load),
                .RST         (r_prim_rst)
            );
`else
            // Behavioural stand-in for the element: tap register in COUNT
            // units, loadable only while VTC is off, cleared by the element
            // reset. The analogue delay itself is not modelled.
            logic [8:0] r_tap;

            always_ff @(posedge clk) begin
                if (r_prim_rst) begin
                    r_tap <= 9'd0;
                end else if (r_load && !r_en_vtc) begin
                    r_tap <= r_latched;
                end
            end

            assign w_cntvalueout = r_tap;
            assign data_out      = data_in;
`endif
        end else begin : g_bad_cfg
            assign w_cntvalueout = r_latched;
            assign data_out      = data_in;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_idelay3_drp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idelay3_drp
//  Purpose  : Self-checking bench for idelay3_drp: directed and random tap
//             writes, reads, collisions and mid-operation resets compared
//             against a simple tap/latency reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idelay3_drp;

    localparam int WRITE_LAT = 25;
    localparam int READ_LAT  = 2;
    localparam int WINDOW    = 40;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic data_in = 1'b0;
    wire  data_out;

    idelay3_drp_if bus ();

    idelay3_drp #(
        .REFCLK_FREQUENCY (300.0),
        .MODE             ("COUNT")
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (data_out),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int model_tap = 0;   // tap value the element should currently hold

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One operation: optional change/read in the same cycle, plus an optional
    // disturbance (a read or a reset pulse) hit_at cycles after acceptance.
    task automatic run_op(input bit do_change, input bit do_read,
                          input logic [8:0] val, input int hit_at,
                          input bit hit_reset, input bit pref_vtc);
        int         done_cnt;
        int         done_at;
        int         load_cnt;
        logic [8:0] load_val;
        bit         vtc_low_c1;
        done_cnt = 0; done_at = 0; load_cnt = 0; load_val = '0; vtc_low_c1 = 1'b0;

        @(negedge clk);
        bus.EN_VTC = pref_vtc;
        @(negedge clk);
        bus.change   = do_change;
        bus.read     = do_read;
        bus.delay_in = val;
        for (int c = 1; c <= WINDOW; c++) begin
            @(posedge clk);
            @(negedge clk);
            data_in = $urandom_range(0, 1);
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (dut.r_load) begin
                load_cnt++;
                load_val = dut.r_latched;
            end
            if (c == 1) begin
                vtc_low_c1   = (dut.r_en_vtc == 1'b0);
                bus.change   = 1'b0;
                bus.read     = 1'b0;
                bus.delay_in = 9'($urandom);
            end
            if (rst_n == 1'b0) rst_n = 1'b1;
            if (hit_at > 0 && hit_at == c) begin
                if (hit_reset) rst_n = 1'b0;
                else           bus.read = 1'b1;
            end else if (hit_at > 0 && hit_at == c - 1 && !hit_reset) begin
                bus.read = 1'b0;
            end
        end

        if (do_change) chk("vtc_off_1cyc", 32'(vtc_low_c1), 32'd1);
        if (hit_reset) begin
            model_tap = 0;
            chk("rst_no_done", 32'(done_cnt), 32'd0);
            chk("rst_no_load", 32'(load_cnt), 32'd0);
            chk("rst_dout", 32'(bus.delay_out), 32'd0);
        end else if (do_change) begin
            model_tap = int'(val);
            chk("wr_done_cnt", 32'(done_cnt), 32'd1);
            chk("wr_latency", 32'(done_at), 32'(WRITE_LAT));
            chk("wr_load_cnt", 32'(load_cnt), 32'd1);
            chk("wr_load_val", 32'(load_val), 32'(val));
            chk("wr_dout", 32'(bus.delay_out), 32'(model_tap));
        end else if (do_read) begin
            chk("rd_done_cnt", 32'(done_cnt), 32'd1);
            chk("rd_latency", 32'(done_at), 32'(READ_LAT));
            chk("rd_load_cnt", 32'(load_cnt), 32'd0);
            chk("rd_dout", 32'(bus.delay_out), 32'(model_tap));
        end
        chk("vtc_restored", 32'(dut.r_en_vtc), 32'(pref_vtc));
    endtask

    initial begin
        int kind;
        bus.read     = 1'b0;
        bus.change   = 1'b0;
        bus.EN_VTC   = 1'b1;
        bus.delay_in = 9'd0;
        rst_n        = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_dout", 32'(bus.delay_out), 32'd0);
        chk("reset_load", 32'(dut.r_load), 32'd0);
        chk("reset_vtc", 32'(dut.r_en_vtc), 32'd1);
        rst_n = 1'b1;

        // directed sequence
        run_op(1'b0, 1'b1, 9'h000, 0, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 9'h0A5, 0, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 9'h1FF, 0, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 9'h000, 0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 9'h000, 0, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 9'h000, 0, 1'b0, 1'b1);
        run_op(1'b1, 1'b1, 9'h033, 0, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 9'h155, 5, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 9'h0C3, 4, 1'b1, 1'b1);
        run_op(1'b0, 1'b1, 9'h000, 0, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 9'h010, 0, 1'b0, 1'b1);

        // random mix
        for (int i = 0; i < 25; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: run_op(1'b1, 1'b0, 9'($urandom), 0, 1'b0, 1'($urandom));
                1: run_op(1'b0, 1'b1, 9'($urandom), 0, 1'b0, 1'($urandom));
                2: run_op(1'b1, 1'b1, 9'($urandom), 0, 1'b0, 1'($urandom));
                3: run_op(1'b1, 1'b0, 9'($urandom), $urandom_range(2, 24), 1'b0, 1'($urandom));
                default: run_op(1'b1, 1'b0, 9'($urandom), $urandom_range(2, 9), 1'b1, 1'($urandom));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
